playground_ram_arb: RTL and testbench
=====================================

# playground_ram_arb

Two-port arbiter and sequencer for the shared 16x4 synchronous RAM in the digital playground. It multiplexes requester A (user I/O port) and requester B (internal pattern player) onto the single RAM port. It uses round-robin priority and tracks writes still in flight inside the RAM's write pipeline, so that no read returns stale data. Sits between the mode-6 I/O decode and the RAM macro.

## Interface
Parameters:
- WR_LAT, 2: RAM write latency; a write issued to the RAM is visible to reads issued WR_LAT or more cycles later.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous and active-low
- a_req, b_req  in  1  request; held stable with the command until granted
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  4  word address
- a_wdata, b_wdata  in  4  write data
- a_gnt, b_gnt  out  1  one-cycle accept pulse (combinational)
- a_rvalid, b_rvalid  out  1  read data valid pulse
- a_rdata, b_rdata  out  4  read data, meaningful only while the matching rvalid is high
- ram_we  out  1  registered RAM write enable
- ram_addr  out  4  registered RAM address
- ram_wdata  out  4  registered RAM write data
- ram_rdata  in  4  RAM registered read data, valid one cycle after the address is presented

## Operation
- Arbitration state is a 1-bit pointer `pref` (0 = A preferred).
- Each cycle, a requester is eligible when its req is high and it is not hazard-blocked.
  - If both are eligible, the preferred one wins.
  - If only one is eligible, it wins, even if it is not preferred.
- On any grant, `pref` moves to the non-granted requester.
  - Consequence: a requester that is always eligible never waits more than one extra grant.
- Commands: the granted command is registered onto ram_* at the end of the grant cycle. If there is no grant, ram_we=0 and ram_addr/ram_wdata hold their previous values.
- Pending-write pipe: a WR_LAT-deep shift register of {valid, addr, data}, pushed on every granted write and advanced every cycle.
- Hazard: a read whose addr matches any valid pending entry.
- Read return: a granted read tags the requester ID through a 2-stage pipe, and rvalid/rdata are delivered to that requester only.
- Boundary cases:
  - Write followed immediately by a read of the same address, from the same or the other requester: hazard handling applies.
  - Different addresses: no hazard, back-to-back grants every cycle.
  - Writes are never hazard-blocked.
  - Address 15 and address 0 are handled identically; there is no address wrap logic.
  - A request dropped before its grant is simply not served.
  - rdata is undefined (don't-care) when rvalid is 0.

## Timing
- Grant: combinational in cycle t from req, pref and the pipe state.
- RAM sees the command in cycle t+1.
- Read: rvalid and rdata in cycle t+2, so latency is 2 cycles from grant.
- Throughput: one command per cycle.
- Reset values:
  - gnt, rvalid, ram_we: 0
  - ram_addr, ram_wdata, rdata: 0
  - pref: 0
  - pending pipe and return pipe: cleared
- Reset mid-operation: in-flight reads are dropped and produce no rvalid. RAM contents are untouched because the RAM is not reset.

## Configuration
- PLAYGROUND_RAM_ARB_FWD_EN defined:
  - Hazard reads are granted without stalling.
  - Data comes from the youngest matching pending entry, registered, and returned at t+2 in place of ram_rdata.
- Macro undefined:
  - Hazard reads get no grant until no matching entry remains (worst case WR_LAT stall cycles).
  - The other requester may be granted during the stall.

## Structure
- playground_pkg holds: RAM_AW=4, RAM_DW=4, and the requester ID enum (REQ_A, REQ_B).
- One sub-module, ram_arb_wpipe: the pending-write shift register with match and youngest-data outputs.
- Arbitration and the return pipe stay in the top module.

## Test plan
- Reset state: assert rst_n=0 mid-read → all outputs 0 immediately, and no rvalid after release.
- Write then read, single requester, no contention: A writes addr 3 = 0xA, then reads addr 3 → a_rvalid 2 cycles after the read grant, a_rdata=0xA.
- Hazard on a back-to-back same-address read: A writes addr 5 = 0x6, then reads addr 5 next cycle.
  - FWD_EN: read granted immediately, rdata=0x6.
  - Without FWD_EN: a_gnt low for 2 cycles, then rdata=0x6.
- Round-robin alternation under continuous requests: A and B request continuously with reads of addr 1 and addr 2 → grants alternate A, B, A, B, and each rvalid routes to the correct port.
- Cross-requester hazard bypass: B writes addr 7 = 0xC while A is stalled on a read of addr 7 (no FWD_EN); B also reads addr 8 → B granted during A's stall; A later reads 0xC.
- Independent address traffic: writes to addr 0 and reads of addr 15 interleaved → no stalls, one grant per cycle.

Source files
------------

// File: rtl/playground_pkg.sv
// playground_pkg
// Shared definitions for the playground RAM arbiter: RAM geometry and the
// requester ID used to route read returns.
package playground_pkg;

  localparam int RAM_AW = 4;
  localparam int RAM_DW = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/playground_ram_arb_wpipe.sv
// ram_arb_wpipe
// Pending-write tracker. Holds every granted write for DEPTH cycles, the time
// the RAM needs before a later read can observe it. Two lookup ports report
// whether an address is still in flight and, if so, the data of the youngest
// matching write.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_push                a write is being granted this cycle
//   i_push_addr/_data     address/data of that write
//   i_addr_a, i_addr_b    lookup addresses (requester A / B)
//   o_hit_a, o_hit_b      address matches a valid pending entry
//   o_data_a, o_data_b    data of the youngest matching entry
module ram_arb_wpipe
  import playground_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [RAM_AW-1:0] i_push_addr,
  input  logic [RAM_DW-1:0] i_push_data,
  input  logic [RAM_AW-1:0] i_addr_a,
  input  logic [RAM_AW-1:0] i_addr_b,
  output logic              o_hit_a,
  output logic              o_hit_b,
  output logic [RAM_DW-1:0] o_data_a,
  output logic [RAM_DW-1:0] o_data_b
);

  // Stage 0 is the youngest entry.
  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0][RAM_AW-1:0] r_addr;
  logic [DEPTH-1:0][RAM_DW-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_vld[0]  <= i_push;
      r_addr[0] <= i_push_addr;
      r_data[0] <= i_push_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  // Scan oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    o_hit_a  = 1'b0;
    o_hit_b  = 1'b0;
    o_data_a = '0;
    o_data_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_vld[i] && (r_addr[i] == i_addr_a)) begin
        o_hit_a  = 1'b1;
        o_data_a = r_data[i];
      end
      if (r_vld[i] && (r_addr[i] == i_addr_b)) begin
        o_hit_b  = 1'b1;
        o_data_b = r_data[i];
      end
    end
  end

endmodule

// File: rtl/playground_ram_arb.sv
// playground_ram_arb
// Round-robin arbiter/sequencer placing requester A (user I/O) and requester
// B (pattern player) onto the single port of the shared 16x4 synchronous RAM.
// Reads that would hit a write still inside the RAM write pipeline are either
// stalled or served by forwarding, so no read returns stale data.
//
// Build option:
//   PLAYGROUND_RAM_ARB_FWD_EN  defined   -> hazard reads granted at once, data
//                                           forwarded from the youngest pending
//                                           write
//                              undefined -> hazard reads wait until the write
//                                           has drained from the pipeline
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata  requester A command (held until granted)
//   b_req/b_we/b_addr/b_wdata  requester B command (held until granted)
//   a_gnt, b_gnt               combinational one-cycle accept pulse
//   a_rvalid/a_rdata           read return to A (2 cycles after grant)
//   b_rvalid/b_rdata           read return to B (2 cycles after grant)
//   ram_we/ram_addr/ram_wdata  registered RAM command
//   ram_rdata                  RAM read data, one cycle after the address
module playground_ram_arb
  import playground_pkg::*;
#(
  parameter int WR_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [RAM_AW-1:0] a_addr,
  input  logic [RAM_DW-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [RAM_AW-1:0] b_addr,
  input  logic [RAM_DW-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic [RAM_DW-1:0] a_rdata,
  output logic              b_rvalid,
  output logic [RAM_DW-1:0] b_rdata,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_wdata,
  input  logic [RAM_DW-1:0] ram_rdata
);

  logic              r_pref;  // 0: A preferred, 1: B preferred
  logic              w_hit_a, w_hit_b;
  logic [RAM_DW-1:0] w_fwd_a, w_fwd_b;
  logic              w_elig_a, w_elig_b;
  logic              w_gnt_a, w_gnt_b, w_any_gnt;
  logic              w_cmd_we, w_cmd_fwd;
  logic [RAM_AW-1:0] w_cmd_addr;
  logic [RAM_DW-1:0] w_cmd_wdata, w_cmd_fdata;

  // Read-return pipe: stage 1 while the RAM sees the address, stage 2 when
  // the RAM data is available.
  logic              r_rv1, r_rv2;
  req_id_e           r_id1, r_id2;
  logic              r_fwd1, r_fwd2;
  logic [RAM_DW-1:0] r_fdata1, r_fdata2;
  logic [RAM_DW-1:0] w_rdata;

  ram_arb_wpipe #(.DEPTH(WR_LAT)) u_wpipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_any_gnt & w_cmd_we),
    .i_push_addr (w_cmd_addr),
    .i_push_data (w_cmd_wdata),
    .i_addr_a    (a_addr),
    .i_addr_b    (b_addr),
    .o_hit_a     (w_hit_a),
    .o_hit_b     (w_hit_b),
    .o_data_a    (w_fwd_a),
    .o_data_b    (w_fwd_b)
  );

`ifdef PLAYGROUND_RAM_ARB_FWD_EN
  assign w_elig_a  = a_req;
  assign w_elig_b  = b_req;
  assign w_cmd_fwd = w_gnt_b ? (w_hit_b & ~b_we) : (w_hit_a & ~a_we);
`else
  // Writes are never blocked; reads wait while their address is in flight.
  assign w_elig_a  = a_req & (a_we | ~w_hit_a);
  assign w_elig_b  = b_req & (b_we | ~w_hit_b);
  assign w_cmd_fwd = 1'b0;
`endif

  // Grants are suppressed while reset is asserted so outputs are quiet.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (rst_n) begin
      if (w_elig_a && w_elig_b) begin
        w_gnt_a = ~r_pref;
        w_gnt_b = r_pref;
      end else begin
        w_gnt_a = w_elig_a;
        w_gnt_b = w_elig_b;
      end
    end
  end

  assign a_gnt       = w_gnt_a;
  assign b_gnt       = w_gnt_b;
  assign w_any_gnt   = w_gnt_a | w_gnt_b;
  assign w_cmd_we    = w_gnt_b ? b_we    : a_we;
  assign w_cmd_addr  = w_gnt_b ? b_addr  : a_addr;
  assign w_cmd_wdata = w_gnt_b ? b_wdata : a_wdata;
  assign w_cmd_fdata = w_gnt_b ? w_fwd_b : w_fwd_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pref    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      r_rv1     <= 1'b0;
      r_id1     <= REQ_A;
      r_fwd1    <= 1'b0;
      r_fdata1  <= '0;
      r_rv2     <= 1'b0;
      r_id2     <= REQ_A;
      r_fwd2    <= 1'b0;
      r_fdata2  <= '0;
    end else begin
      ram_we <= w_any_gnt & w_cmd_we;
      if (w_any_gnt) begin
        ram_addr  <= w_cmd_addr;
        ram_wdata <= w_cmd_wdata;
        r_pref    <= w_gnt_a;  // preference moves to the loser
      end
      r_rv1    <= w_any_gnt & ~w_cmd_we;
      r_id1    <= w_gnt_b ? REQ_B : REQ_A;
      r_fwd1   <= w_cmd_fwd;
      r_fdata1 <= w_cmd_fdata;
      r_rv2    <= r_rv1;
      r_id2    <= r_id1;
      r_fwd2   <= r_fwd1;
      r_fdata2 <= r_fdata1;
    end
  end

  assign w_rdata  = r_fwd2 ? r_fdata2 : ram_rdata;
  assign a_rvalid = r_rv2 & (r_id2 == REQ_A);
  assign b_rvalid = r_rv2 & (r_id2 == REQ_B);
  // Data is forced to zero when not valid so reset and idle values are clean.
  assign a_rdata  = a_rvalid ? w_rdata : '0;
  assign b_rdata  = b_rvalid ? w_rdata : '0;

endmodule

// File: tb/tb_playground_ram_arb.sv
module tb_playground_ram_arb;

`ifdef PLAYGROUND_RAM_ARB_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we;
  logic [3:0] a_rdata, b_rdata, ram_addr, ram_wdata, ram_rdata;

  playground_ram_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .a_gnt     (a_gnt),
    .b_gnt     (b_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, a write becomes visible to reads issued two
  // or more cycles after it was issued.
  logic [3:0] mem [16];
  logic       d_we;
  logic [3:0] d_addr, d_data;
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (d_we) mem[d_addr] <= d_data;
    d_we   <= ram_we;
    d_addr <= ram_addr;
    d_data <= ram_wdata;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard: shadow memory in grant order, expected data/cycle per port.
  logic [3:0] shadow [16];
  int qa_d[$], qa_c[$], qb_d[$], qb_c[$];

  task automatic cmd(input bit is_b, input logic we, input logic [3:0] addr,
                     input logic [3:0] data, output int waits, output int gcyc);
    int n = 0;
    bit got = 0;
    if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    while (!got && n <= 40) begin
      @(negedge clk);
      if (is_b ? b_gnt : a_gnt) got = 1;
      else n++;
    end
    waits = n;
    gcyc  = cyc;
    if (!got) chk("gnt_timeout", n, 0);
    else if (we) shadow[addr] = data;
    else if (is_b) begin qb_d.push_back(int'(shadow[addr])); qb_c.push_back(cyc + 2); end
    else begin qa_d.push_back(int'(shadow[addr])); qa_c.push_back(cyc + 2); end
    @(posedge clk); #1;
    if (is_b) b_req = 0; else a_req = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_gnt | b_gnt) chk("gnt_onehot", a_gnt & b_gnt, 0);
      if (a_rvalid) begin
        if (qa_d.size() == 0) chk("a_rv_unexpected", qa_d.size(), 1);
        else begin
          chk("a_rdata", a_rdata, qa_d.pop_front());
          chk("a_rlat", cyc, qa_c.pop_front());
        end
      end
      if (b_rvalid) begin
        if (qb_d.size() == 0) chk("b_rv_unexpected", qb_d.size(), 1);
        else begin
          chk("b_rdata", b_rdata, qb_d.pop_front());
          chk("b_rlat", cyc, qb_c.pop_front());
        end
      end
    end
  end

  int n0, g0, n1, g1, na, nb, gbw, gb8, gax;
  int ga[4], gb[4];

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = '0; shadow[i] = '0; end
    d_we = 0; ram_rdata = '0;
    rst_n = 0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    #12;
    chk("reset_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_addr, ram_wdata, a_rdata, b_rdata}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Write then read, no contention, no hazard.
    cmd(0, 1, 4'd3, 4'hA, n0, g0);
    cmd(0, 1, 4'd1, 4'h9, n0, g0);
    cmd(1, 1, 4'd2, 4'h4, n0, g0);
    repeat (4) @(posedge clk); #1;
    cmd(0, 0, 4'd3, 4'h0, n0, g0);
    chk("plain_rd_wait", n0, 0);
    repeat (4) @(posedge clk); #1;

    // Back-to-back same-address read from the same requester.
    cmd(0, 1, 4'd5, 4'h6, n0, g0);
    cmd(0, 0, 4'd5, 4'h0, n1, g1);
    chk("haz_gap", g1 - g0, FWD ? 1 : 1 + 2);
    repeat (5) @(posedge clk); #1;

    // Reset in the middle of a read.
    cmd(0, 0, 4'd3, 4'h0, n0, g0);
    b_req = 1; b_we = 0; b_addr = 4'd4;
    rst_n = 0;
    #1;
    chk("midrst_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, ram_addr, ram_wdata, a_rdata, b_rdata}, 0);
    qa_d.delete(); qa_c.delete(); qb_d.delete(); qb_c.delete();
    repeat (2) @(negedge clk);
    b_req = 0; rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rv", {a_rvalid, b_rvalid}, 0);
    end
    @(posedge clk); #1;

    // Round robin under continuous reads; pref restarts at A after reset.
    fork
      begin for (int i = 0; i < 4; i++) cmd(0, 0, 4'd1, 4'h0, na, ga[i]); end
      begin for (int i = 0; i < 4; i++) cmd(1, 0, 4'd2, 4'h0, nb, gb[i]); end
    join
    chk("rr_first", gb[0] - ga[0], 1);
    for (int i = 1; i < 4; i++) begin
      chk("rr_gap_a", ga[i] - ga[i-1], 2);
      chk("rr_gap_b", gb[i] - gb[i-1], 2);
    end
    repeat (4) @(posedge clk); #1;

    // Cross-requester hazard: A's read of 7 trails B's write of 7.
    fork
      begin
        cmd(1, 1, 4'd7, 4'hC, nb, gbw);
        cmd(1, 0, 4'd8, 4'h0, nb, gb8);
      end
      begin
        int k = 0;
        do begin @(negedge clk); k++; end while (!b_gnt && k < 40);
        if (!b_gnt) chk("cross_wait_timeout", k, 0);
        @(posedge clk); #1;
        cmd(0, 0, 4'd7, 4'h0, na, gax);
      end
    join
    chk("cross_a_gap", gax - gbw, FWD ? 1 : 3);
    chk("cross_b_gap", gb8 - gbw, FWD ? 2 : 1);
    repeat (4) @(posedge clk); #1;

    // Independent addresses from one requester: one grant per cycle.
    g0 = 0;
    for (int i = 0; i < 6; i++) begin
      cmd(0, (i % 2) == 0, (i % 2) == 0 ? 4'd0 : 4'd15, 4'(i + 1), n1, g1);
      chk("indep_wait", n1, 0);
      if (i > 0) chk("indep_gap", g1 - g0, 1);
      g0 = g1;
    end
    // Both requesters: writes of 0 against reads of 15, no stalls.
    fork
      begin for (int i = 0; i < 3; i++) cmd(0, 1, 4'd0, 4'(8 + i), na, ga[i]); end
      begin for (int i = 0; i < 3; i++) cmd(1, 0, 4'd15, 4'h0, nb, gb[i]); end
    join
    chk("mix_first", gb[0] - ga[0], -1);
    for (int i = 1; i < 3; i++) begin
      chk("mix_gap_a", ga[i] - ga[i-1], 2);
      chk("mix_gap_b", gb[i] - gb[i-1], 2);
    end
    cmd(1, 0, 4'd0, 4'h0, nb, g1);

    repeat (6) @(negedge clk);
    chk("qa_drained", qa_d.size(), 0);
    chk("qb_drained", qb_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
